// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard controller.
//   fsm_t       frame receiver states
//   SC_*        scan codes recognised by the decoder
//   KEY_*       bit positions inside keys_held
//   map_key()   (code, ext) -> keys_held bit lookup
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } fsm_t;

  // Prefixes and keyboard housekeeping bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;

  // Game-control scan codes
  localparam logic [7:0] SC_LEFT   = 8'h6B;  // E0-prefixed
  localparam logic [7:0] SC_RIGHT  = 8'h74;  // E0-prefixed
  localparam logic [7:0] SC_DOWN   = 8'h72;  // E0-prefixed
  localparam logic [7:0] SC_ROT_CW = 8'h75;  // E0-prefixed
  localparam logic [7:0] SC_ROT_CC = 8'h1A;
  localparam logic [7:0] SC_DROP   = 8'h29;
  localparam logic [7:0] SC_HOLD   = 8'h21;
  localparam logic [7:0] SC_PAUSE  = 8'h76;

  localparam logic [2:0] KEY_LEFT   = 3'd0;
  localparam logic [2:0] KEY_RIGHT  = 3'd1;
  localparam logic [2:0] KEY_DOWN   = 3'd2;
  localparam logic [2:0] KEY_ROT_CW = 3'd3;
  localparam logic [2:0] KEY_ROT_CC = 3'd4;
  localparam logic [2:0] KEY_DROP   = 3'd5;
  localparam logic [2:0] KEY_HOLD   = 3'd6;
  localparam logic [2:0] KEY_PAUSE  = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  // The extended flag is part of the key identity: 6B without E0 is the
  // keypad '4', not the arrow key, and must not touch keys_held.
  function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = KEY_LEFT;
    if      ( ext && code == SC_LEFT  ) m.idx = KEY_LEFT;
    else if ( ext && code == SC_RIGHT ) m.idx = KEY_RIGHT;
    else if ( ext && code == SC_DOWN  ) m.idx = KEY_DOWN;
    else if ( ext && code == SC_ROT_CW) m.idx = KEY_ROT_CW;
    else if (!ext && code == SC_ROT_CC) m.idx = KEY_ROT_CC;
    else if (!ext && code == SC_DROP  ) m.idx = KEY_DROP;
    else if (!ext && code == SC_HOLD  ) m.idx = KEY_HOLD;
    else if (!ext && code == SC_PAUSE ) m.idx = KEY_PAUSE;
    else                                m.hit = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ps2_keyboard_ctrl_if.sv
// ps2_keyboard_ctrl_if: PS/2 pins plus the decoded key-event bus.
//   ps2_clk, ps2_data   raw PS/2 lines (asynchronous)
//   key_valid           one-cycle event strobe
//   key_code/ext/break  event payload, held until the next event
//   keys_held           level bitmap of game controls
//   frame_err           one-cycle frame error pulse
// master: the controller; slave: the pin driver / event consumer.
interface ps2_keyboard_ctrl_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] keys_held;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key_valid, key_code, key_ext, key_break, keys_held, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_valid, key_code, key_ext, key_break, keys_held, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: single-clock PS/2 frame receiver.
//   clk, rst      system clock, synchronous active-high reset
//   ps2_clk_i     raw PS/2 clock
//   ps2_data_i    raw PS/2 data
//   byte_ok_o     one-cycle pulse, byte_o holds a validated byte
//   byte_o        received data byte
//   frame_err_o   one-cycle pulse on parity, stop-bit or timeout error
// Both lines are synchronised, the clock is glitch-filtered, and each
// falling edge of the filtered clock strobes one bit into the frame FSM.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_ok_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic [FW-1:0] flt_cnt_q;
  logic          kclk_f_q, kclk_prev_q;
  logic          strobe;

  fsm_t          state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] wd_q;
  logic          byte_ok_q, frame_err_q;

  // Synchroniser and clock filter. The lines idle high, so every stage
  // resets to 1 to avoid a false falling edge right after reset.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the
  // two-stage synchroniser into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      flt_cnt_q   <= '0;
      kclk_f_q    <= 1'b1;
      kclk_prev_q <= 1'b1;
    end else begin
      clk_s1_q    <= ps2_clk_i;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= ps2_data_i;
      data_s2_q   <= data_s1_q;
      kclk_prev_q <= kclk_f_q;
      // Count consecutive samples that disagree with the filtered level;
      // the FILTER_LEN-th one in a row flips it, any agreement restarts.
      if (clk_s2_q != kclk_f_q) begin
        if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
          kclk_f_q  <= clk_s2_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + FW'(1);
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  assign strobe = kclk_prev_q & ~kclk_f_q;

  // Frame FSM and watchdog. A strobe takes priority over an expiring
  // watchdog, so a bit arriving exactly at the limit still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wd_q        <= '0;
      byte_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (strobe) begin
        wd_q <= '0;
        unique case (state_q)
          IDLE: begin
            // A high "start bit" is a stray edge, not a frame.
            if (!data_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {data_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= data_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            if (data_s2_q && (^{shift_q, par_q})) byte_ok_q   <= 1'b1;
            else                                  frame_err_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q == IDLE) begin
        wd_q <= '0;
      end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        wd_q        <= '0;
      end else begin
        wd_q <= wd_q + TW'(1);
      end
    end
  end

  assign byte_ok_o   = byte_ok_q;
  assign byte_o      = shift_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl: PS/2 keyboard front end for the game controls.
//   clk, rst   system clock, synchronous active-high reset
//   bus        ps2_keyboard_ctrl_if.master: PS/2 pins in, key events out
// Validated bytes from ps2_frame_rx are folded through the E0/F0 prefix
// state into one-cycle key events and a held-key bitmap.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic                       clk,
  input  logic                       rst,
  ps2_keyboard_ctrl_if.master        bus
);

  logic       rx_byte_ok, rx_frame_err;
  logic [7:0] rx_byte;
  key_map_t   km;

  logic       ext_pend_q,  ext_pend_d;
  logic       brk_pend_q,  brk_pend_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q,  key_code_d;
  logic       key_ext_q,   key_ext_d;
  logic       key_break_q, key_break_d;
  logic [7:0] keys_held_q, keys_held_d;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .byte_ok_o   (rx_byte_ok),
    .byte_o      (rx_byte),
    .frame_err_o (rx_frame_err)
  );

  assign km = map_key(rx_byte, ext_pend_q);

  always_comb begin
    // NOTE: every _d starts from its hold value so no path through the
    // decode leaves a signal unassigned (which would infer a latch).
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    keys_held_d = keys_held_q;

    if (rx_frame_err) begin
      // A lost byte may have been part of a prefixed sequence.
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_byte_ok) begin
      case (rx_byte)
        SC_E0: ext_pend_d = 1'b1;
        SC_F0: brk_pend_d = 1'b1;
        SC_AA, SC_FA, SC_EE, SC_FE: begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
        default: begin
          key_valid_d = 1'b1;
          key_code_d  = rx_byte;
          key_ext_d   = ext_pend_q;
          key_break_d = brk_pend_q;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
          if (km.hit) keys_held_d[km.idx] = ~brk_pend_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      keys_held_q <= '0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      keys_held_q <= keys_held_d;
    end
  end

  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_break = key_break_q;
  assign bus.keys_held = keys_held_q;
  assign bus.frame_err = rx_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// tb_ps2_keyboard_ctrl: directed bench for ps2_keyboard_ctrl.
// System clock 6.25 MHz (160 ns) so a 40 us PS/2 bit period is 250 cycles,
// comfortably inside TIMEOUT_CYCLES=2000 between falling edges.
`timescale 1ns/1ps
module tb_ps2_keyboard_ctrl;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int Q1 = 62, HALF = 125, Q2 = 63;  // one 250-cycle bit
  localparam int GAP = 250;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #80 clk = ~clk;

  ps2_keyboard_ctrl_if bus ();

  ps2_keyboard_ctrl #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Event monitor: counts pulses and latches the payload seen with each
  // key_valid, sampled on the falling system clock edge.
  int         cyc = 0;
  int         fall_cyc = 0;
  int         ev_cnt = 0;
  int         err_cnt = 0;
  int         ev_lat = 0;
  logic [7:0] ev_code = '0;
  logic       ev_ext = 1'b0, ev_brk = 1'b0;
  logic [7:0] ev_held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      ev_cnt  = ev_cnt + 1;
      ev_code = bus.key_code;
      ev_ext  = bus.key_ext;
      ev_brk  = bus.key_break;
      ev_held = bus.keys_held;
      ev_lat  = cyc - fall_cyc;
    end
    if (bus.frame_err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(Q1);
    bus.ps2_clk = 1'b0;
    fall_cyc    = cyc;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
    wait_cyc(Q2);
  endtask

  // Sends the first nbits of an 11-bit frame, LSB first after the start bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^b) ^ bad_par;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    bus.ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic test_reset;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    n_cmp++;
    if ({bus.key_valid, bus.key_ext, bus.key_break, bus.frame_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.key_valid, bus.key_ext, bus.key_break, bus.frame_err});
    end
    n_cmp++;
    if ({bus.key_code, bus.keys_held} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_code_held: got %h want 0000", {bus.key_code, bus.keys_held});
    end
  endtask

  task automatic test_make;
    int e0, r0;
    e0 = ev_cnt; r0 = err_cnt;
    send_byte(8'h1A);
    n_cmp++;
    if (ev_cnt - e0 !== 1) begin
      n_bad++; $display("FAIL make_count: got %0d want 1", ev_cnt - e0);
    end
    n_cmp++;
    if ({ev_code, ev_ext, ev_brk} !== {8'h1A, 2'b00}) begin
      n_bad++; $display("FAIL make_event: got %h/%b%b want 1a/00", ev_code, ev_ext, ev_brk);
    end
    n_cmp++;
    if (ev_held !== 8'h10) begin
      n_bad++; $display("FAIL make_held: got %h want 10", ev_held);
    end
    // Stop-bit fall -> 2 sync + 8 filter -> strobe -> byte_ok -> key_valid
    n_cmp++;
    if (ev_lat !== 2 + FILTER_LEN + 2) begin
      n_bad++; $display("FAIL make_latency: got %0d want %0d", ev_lat, 2 + FILTER_LEN + 2);
    end
    n_cmp++;
    if (err_cnt - r0 !== 0) begin
      n_bad++; $display("FAIL make_err: got %0d want 0", err_cnt - r0);
    end
  endtask

  task automatic test_extended;
    int e0;
    e0 = ev_cnt;
    send_byte(8'hE0);
    send_byte(8'h6B);
    n_cmp++;
    if ({ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held} !== {32'd1, 8'h6B, 2'b10, 8'h11}) begin
      n_bad++;
      $display("FAIL ext_make: got n=%0d %h/%b%b held=%h want n=1 6b/10 held=11",
               ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held);
    end
    e0 = ev_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    n_cmp++;
    if ({ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held} !== {32'd1, 8'h6B, 2'b11, 8'h10}) begin
      n_bad++;
      $display("FAIL ext_break: got n=%0d %h/%b%b held=%h want n=1 6b/11 held=10",
               ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held);
    end
  endtask

  task automatic test_parity_error;
    int e0, r0;
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h29, 1'b1, 11);
    n_cmp++;
    if ({err_cnt - r0, ev_cnt - e0} !== {32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL parity_err: got err=%0d ev=%0d want err=1 ev=0", err_cnt - r0, ev_cnt - e0);
    end
    n_cmp++;
    if (bus.key_code !== 8'h6B) begin
      n_bad++; $display("FAIL parity_code_hold: got %h want 6b", bus.key_code);
    end
    e0 = ev_cnt;
    send_byte(8'hF0);
    send_byte(8'h29);
    n_cmp++;
    if ({ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held} !== {32'd1, 8'h29, 2'b01, 8'h10}) begin
      n_bad++;
      $display("FAIL parity_recover: got n=%0d %h/%b%b held=%h want n=1 29/01 held=10",
               ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held);
    end
  endtask

  task automatic test_timeout;
    int e0, r0;
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h55, 1'b0, 6);  // start + 5 data bits, then silence
    wait_cyc(1700 - GAP);        // still short of TIMEOUT since last strobe
    n_cmp++;
    if (err_cnt - r0 !== 0) begin
      n_bad++; $display("FAIL timeout_early: got %0d want 0", err_cnt - r0);
    end
    wait_cyc(400);
    n_cmp++;
    if ({err_cnt - r0, ev_cnt - e0} !== {32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%0d ev=%0d want err=1 ev=0", err_cnt - r0, ev_cnt - e0);
    end
    send_byte(8'h76);
    n_cmp++;
    if ({ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held} !== {32'd1, 8'h76, 2'b00, 8'h90}) begin
      n_bad++;
      $display("FAIL timeout_recover: got n=%0d %h/%b%b held=%h want n=1 76/00 held=90",
               ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held);
    end
  endtask

  task automatic test_glitch_and_control;
    int e0, r0;
    e0 = ev_cnt; r0 = err_cnt;
    bus.ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    bus.ps2_clk = 1'b1;
    wait_cyc(50);
    send_byte(8'hF0);
    send_byte(8'hAA);
    n_cmp++;
    if ({ev_cnt - e0, err_cnt - r0, bus.keys_held} !== {32'd0, 32'd0, 8'h90}) begin
      n_bad++;
      $display("FAIL glitch_aa: got ev=%0d err=%0d held=%h want ev=0 err=0 held=90",
               ev_cnt - e0, err_cnt - r0, bus.keys_held);
    end
    // AA must have dropped the pending F0, so this is a make, not a break.
    send_byte(8'h76);
    n_cmp++;
    if ({ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held} !== {32'd1, 8'h76, 2'b00, 8'h90}) begin
      n_bad++;
      $display("FAIL aa_clears_prefix: got n=%0d %h/%b%b held=%h want n=1 76/00 held=90",
               ev_cnt - e0, ev_code, ev_ext, ev_brk, ev_held);
    end
  endtask

  task automatic test_reset_mid_sequence;
    int e0, r0;
    send_byte(8'hE0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    r0 = err_cnt; e0 = ev_cnt;
    n_cmp++;
    if ({bus.key_valid, bus.key_code, bus.key_ext, bus.key_break, bus.keys_held, bus.frame_err}
        !== 20'h0) begin
      n_bad++;
      $display("FAIL rst_outputs: code=%h held=%h flags=%b%b%b%b want all 0",
               bus.key_code, bus.keys_held, bus.key_valid, bus.key_ext, bus.key_break,
               bus.frame_err);
    end
    send_byte(8'h6B);
    n_cmp++;
    if ({ev_cnt - e0, err_cnt - r0, ev_code, ev_ext, ev_brk, ev_held}
        !== {32'd1, 32'd0, 8'h6B, 2'b00, 8'h00}) begin
      n_bad++;
      $display("FAIL rst_prefix_clear: got n=%0d err=%0d %h/%b%b held=%h want n=1 err=0 6b/00 held=00",
               ev_cnt - e0, err_cnt - r0, ev_code, ev_ext, ev_brk, ev_held);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_extended();
    test_parity_error();
    test_timeout();
    test_glitch_and_control();
    test_reset_mid_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
